alu_sequencer: RTL

Multi-cycle initiator that drives the combinational gate-level ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's A/B/Ctrl inputs. It waits a programmable settle time, because the gate delays of the ripple-carry chain and the 32-input zero NOR exceed one clock period, then captures the result and flags. It also performs 32-bit multiply iteratively by issuing repeated ALU ADDs. It sits between the issue/decode stage and the ALU.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_settle_counter.sv | 33 +++
 rtl/alu_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sequencer.
//   - ALU_W            datapath width of the gate-level ALU
//   - OP_*             request / ALU control op codes
//   - seq_state_t      sequencer FSM states
//   - op_is_single()   true for ops the ALU performs in one pass
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT      = 3'd1,
    ST_MUL_CHECK = 3'd2,
    ST_MUL_WAIT  = 3'd3,
    ST_RESP      = 3'd4
  } seq_state_t;

  // ADD/SUB/XOR/SLT all live in the lower half of the op space.
  function automatic logic op_is_single(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// alu_settle_counter: down-counter that times the ALU settle window.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   load        load load_val (takes priority over dec)
//   load_val    value to load (settle cycles minus one)
//   dec         decrement by one, saturating at zero
//   done        count has reached zero
module alu_settle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle initiator for the combinational gate-level ALU.
// Accepts one request at a time (req_*), drives the ALU inputs (alu_a/b/ctrl),
// waits SETTLE_CYCLES edges for the ripple chain to settle, captures the ALU
// result and flags and presents them on rsp_* until rsp_ready.
// Ports:
//   clk, rst_n                    clock / asynchronous active-low reset
//   req_valid/ready, req_op/a/b   request handshake and operands
//   rsp_valid/ready, rsp_*        response handshake, result and flags
//   alu_a/b/ctrl                  registered drive to the ALU
//   alu_out/zero/overflow/cout    ALU outputs (sampled after settling)
// Build option: define ALU_SEQ_MUL_EN to enable iterative MUL (op 100) via
// repeated ALU ADDs; without it op 100 is answered as illegal.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [ALU_W-1:0] req_a,
  input  logic [ALU_W-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_cout,
  output logic             rsp_illegal,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [ALU_W-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_cout
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  seq_state_t       state_reg, state_next;
  logic [ALU_W-1:0] alu_a_reg, alu_a_next;
  logic [ALU_W-1:0] alu_b_reg, alu_b_next;
  logic [2:0]       alu_ctrl_reg, alu_ctrl_next;
  logic [ALU_W-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             ovf_reg, ovf_next;
  logic             cout_reg, cout_next;
  logic             illegal_reg, illegal_next;
`ifdef ALU_SEQ_MUL_EN
  logic [ALU_W-1:0] acc_reg, acc_next;
  logic [ALU_W-1:0] m_reg, m_next;
  logic [ALU_W-1:0] q_reg, q_next;
`endif
  logic             cnt_load, cnt_dec, cnt_done;

  alu_settle_counter #(.WIDTH(8)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_ctrl_reg <= OP_ADD;
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      cout_reg     <= 1'b0;
      illegal_reg  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_reg      <= '0;
      m_reg        <= '0;
      q_reg        <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      alu_a_reg    <= alu_a_next;
      alu_b_reg    <= alu_b_next;
      alu_ctrl_reg <= alu_ctrl_next;
      result_reg   <= result_next;
      zero_reg     <= zero_next;
      ovf_reg      <= ovf_next;
      cout_reg     <= cout_next;
      illegal_reg  <= illegal_next;
`ifdef ALU_SEQ_MUL_EN
      acc_reg      <= acc_next;
      m_reg        <= m_next;
      q_reg        <= q_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    alu_a_next    = alu_a_reg;
    alu_b_next    = alu_b_reg;
    alu_ctrl_next = alu_ctrl_reg;
    result_next   = result_reg;
    zero_next     = zero_reg;
    ovf_next      = ovf_reg;
    cout_next     = cout_reg;
    illegal_next  = illegal_reg;
`ifdef ALU_SEQ_MUL_EN
    acc_next      = acc_reg;
    m_next        = m_reg;
    q_next        = q_reg;
`endif
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (op_is_single(req_op)) begin
            alu_a_next    = req_a;
            alu_b_next    = req_b;
            alu_ctrl_next = req_op;
            cnt_load      = 1'b1;
            state_next    = ST_WAIT;
          end
`ifdef ALU_SEQ_MUL_EN
          else if (req_op == OP_MUL) begin
            acc_next   = '0;
            m_next     = req_a;
            q_next     = req_b;
            state_next = ST_MUL_CHECK;
          end
`endif
          else begin
            // Unsupported op: answer immediately, ALU drive untouched.
            result_next  = '0;
            zero_next    = 1'b1;
            ovf_next     = 1'b0;
            cout_next    = 1'b0;
            illegal_next = 1'b1;
            state_next   = ST_RESP;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_done) begin
          result_next  = alu_out;
          zero_next    = alu_zero;
          ovf_next     = alu_overflow;
          cout_next    = alu_cout;
          illegal_next = 1'b0;
          state_next   = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end

`ifdef ALU_SEQ_MUL_EN
      // Shift-and-add: one ALU ADD per set bit of the multiplier, zero bits
      // just shift. Stops as soon as no multiplier bits remain.
      ST_MUL_CHECK: begin
        if (q_reg == '0) begin
          result_next  = acc_reg;
          zero_next    = (acc_reg == '0);
          ovf_next     = 1'b0;
          cout_next    = 1'b0;
          illegal_next = 1'b0;
          state_next   = ST_RESP;
        end else if (q_reg[0]) begin
          alu_a_next    = acc_reg;
          alu_b_next    = m_reg;
          alu_ctrl_next = OP_ADD;
          cnt_load      = 1'b1;
          state_next    = ST_MUL_WAIT;
        end else begin
          m_next = m_reg << 1;
          q_next = q_reg >> 1;
        end
      end

      ST_MUL_WAIT: begin
        if (cnt_done) begin
          acc_next   = alu_out;
          m_next     = m_reg << 1;
          q_next     = q_reg >> 1;
          state_next = ST_MUL_CHECK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`endif

      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign req_ready    = (state_reg == ST_IDLE);
  assign rsp_valid    = (state_reg == ST_RESP);
  assign rsp_result   = result_reg;
  assign rsp_zero     = zero_reg;
  assign rsp_overflow = ovf_reg;
  assign rsp_cout     = cout_reg;
  assign rsp_illegal  = illegal_reg;
  assign alu_a        = alu_a_reg;
  assign alu_b        = alu_b_reg;
  assign alu_ctrl     = alu_ctrl_reg;

endmodule
